// File: rtl/touch_pkg.sv
// Shared constants, state encodings and the event record for the touch packet receiver.
package touch_pkg;
  localparam logic [7:0] HDR_UP      = 8'h80;
  localparam logic [7:0] HDR_DN      = 8'h81;
  localparam int         COORD_MAX_W = 14;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [2:0] {P_HDR, P_X0, P_X1, P_Y0, P_Y1} parse_state_t;

  typedef struct packed {
    logic                   pen;
    logic [COORD_MAX_W-1:0] x;
    logic [COORD_MAX_W-1:0] y;
  } touch_event_t;

  function automatic logic is_hdr(input logic [7:0] b);
    return (b == HDR_UP) || (b == HDR_DN);
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, registered byte_valid/frame_err.
module uart_rx_byte
  import touch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  logic [1:0]    sync;
  logic          rxd_s, rxd_d, fall;
  uart_state_t   state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_clr, samp, stop_samp;

  assign rxd_s = sync[1];
  assign fall  = rxd_d & ~rxd_s;

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    samp      = 1'b0;
    stop_samp = 1'b0;
    case (state)
      U_IDLE:  if (fall) begin
        state_n = U_START;
        cnt_clr = 1'b1;
      end
      U_START: if (cnt == CW'(HALF - 1)) begin
        cnt_clr = 1'b1;
        state_n = rxd_s ? U_IDLE : U_DATA;   // high at mid-start = glitch
      end
      U_DATA:  if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt_clr = 1'b1;
        samp    = 1'b1;
        if (bit_idx == 3'd7) state_n = U_STOP;
      end
      U_STOP:  if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt_clr   = 1'b1;
        stop_samp = 1'b1;
        state_n   = U_IDLE;
      end
      default: state_n = U_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync       <= 2'b11;
      rxd_d      <= 1'b1;
      state      <= U_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rxd};
      rxd_d      <= rxd_s;
      state      <= state_n;
      cnt        <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == U_START) bit_idx <= '0;
      if (samp) begin
        shreg   <= {rxd_s, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      byte_valid <= stop_samp & rxd_s;
      frame_err  <= stop_samp & ~rxd_s;
    end
  end

  assign rx_byte = shreg;
endmodule

// File: rtl/touch_packet_rx.sv
// Touch controller packet receiver: UART bytes -> 5-byte packet parser -> event FIFO.
// Optional TOUCH_ERR_CNT_EN adds a saturating err_count output.
module touch_packet_rx
  import touch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int COORD_W      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rxd,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic               ev_pen,
  output logic [COORD_W-1:0] ev_x,
  output logic [COORD_W-1:0] ev_y,
  output logic               overflow,
  output logic               frame_err
`ifdef TOUCH_ERR_CNT_EN
  ,
  output logic [15:0]        err_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       byte_valid;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // Parser
  parse_state_t     p, p_n;
  logic             pen_r;
  logic [6:0]       x0_r, y0_r;
  logic [COORD_W-8:0] x1_r;
  logic             push, err_inc, hdr_path;
  touch_event_t     new_ev;

  assign hdr_path = byte_valid && (p == P_HDR || rx_byte[7]);

  always_comb begin
    p_n     = p;
    push    = 1'b0;
    err_inc = 1'b0;
    if (frame_err) begin
      p_n = P_HDR;
    end else if (hdr_path) begin
      // Any bit7 byte restarts framing; mid-packet ones count as a resync.
      err_inc = (p != P_HDR) || !is_hdr(rx_byte);
      p_n     = is_hdr(rx_byte) ? P_X0 : P_HDR;
    end else if (byte_valid) begin
      case (p)
        P_X0:    p_n = P_X1;
        P_X1:    p_n = P_Y0;
        P_Y0:    p_n = P_Y1;
        P_Y1:    begin p_n = P_HDR; push = 1'b1; end
        default: p_n = P_HDR;
      endcase
    end
  end

  always_comb begin
    new_ev              = '0;
    new_ev.pen          = pen_r;
    new_ev.x[COORD_W-1:0] = {x1_r, x0_r};
    new_ev.y[COORD_W-1:0] = {rx_byte[COORD_W-8:0], y0_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p     <= P_HDR;
      pen_r <= 1'b0;
      x0_r  <= '0;
      x1_r  <= '0;
      y0_r  <= '0;
    end else begin
      p <= p_n;
      if (hdr_path && is_hdr(rx_byte)) pen_r <= rx_byte[0];
      if (byte_valid && !rx_byte[7]) begin
        case (p)
          P_X0:    x0_r <= rx_byte[6:0];
          P_X1:    x1_r <= rx_byte[COORD_W-8:0];
          P_Y0:    y0_r <= rx_byte[6:0];
          default: ;
        endcase
      end
    end
  end

  // Event FIFO; pointers carry an extra MSB to split full from empty
  touch_event_t mem [FIFO_DEPTH];
  touch_event_t head;
  logic [AW:0]  wptr, rptr;
  logic         empty, full, pop, wr, drop;
  logic         unused_hi;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = ev_valid & ev_ready;
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= new_ev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)   wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign head      = mem[rptr[AW-1:0]];
  assign ev_valid  = ~empty;
  assign ev_pen    = ev_valid & head.pen;
  assign ev_x      = ev_valid ? head.x[COORD_W-1:0] : '0;
  assign ev_y      = ev_valid ? head.y[COORD_W-1:0] : '0;
  assign unused_hi = ^{head.x, head.y};

`ifdef TOUCH_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) err_count <= '0;
    else if ((err_inc | frame_err | drop) && err_count != 16'hFFFF)
      err_count <= err_count + 1'b1;
  end
`endif
endmodule

// File: doc/touch_packet_rx.md
TOUCH_PACKET_RX -- requirements
Module: touch_packet_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter COORD_W, default 12: coordinate width; 7 < COORD_W <= 14.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rxd  in  1  asynchronous UART line from the touch controller, idle high.
REQ-007 SHALL have port ev_valid  out  1  FIFO head event available.
REQ-008 SHALL have port ev_ready  in  1  consumer accepts head event.
REQ-009 SHALL have port ev_pen  out  1  head event pen state, 1 = down.
REQ-010 SHALL have port ev_x  out  COORD_W  head event X coordinate.
REQ-011 SHALL have port ev_y  out  COORD_W  head event Y coordinate.
REQ-012 SHALL have port overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
REQ-013 SHALL have port frame_err  out  1  one-cycle pulse: stop bit sampled low.

Function
REQ-014 SHALL pass rxd through a 2-flop synchroniser; all UART logic SHALL use the synchronised value.
REQ-015 UART FSM states: IDLE, START, DATA, STOP. IDLE->START on a synchronised falling edge.
REQ-016 START SHALL resample the line at CLKS_PER_BIT/2; low -> DATA, high -> IDLE (glitch rejected, no byte).
REQ-017 DATA SHALL sample 8 bits LSB first, one every CLKS_PER_BIT cycles; STOP SHALL sample one bit after that; then -> IDLE.
REQ-018 A high stop bit SHALL pulse an internal byte_valid on the following cycle.
REQ-019 A low stop bit SHALL pulse frame_err on the following cycle, drop the byte, and return the parser to HDR.
REQ-020 Parser states: HDR, X0, X1, Y0, Y1.
REQ-021 In HDR, byte 0x80 (pen up) or 0x81 (pen down) SHALL latch pen and -> X0; any other byte SHALL be discarded.
REQ-022 In X0..Y1, a byte with bit7 = 1 SHALL resynchronise: it is reprocessed as a header and the partial packet is discarded.
REQ-023 Coordinates: x = {X1[COORD_W-8:0], X0[6:0]}, y = {Y1[COORD_W-8:0], Y0[6:0]}; unused high bits of X1/Y1 ignored.
REQ-024 A valid Y1 byte SHALL push {pen, x, y} into the FIFO in the byte_valid cycle, then -> HDR.
REQ-025 Latency: stop-bit sample in cycle S, byte_valid in S+1; with an empty FIFO, ev_valid SHALL be 1 in S+2.
REQ-026 FIFO output: ev_* SHALL hold stable while ev_valid=1 and ev_ready=0; pop occurs when ev_valid & ev_ready.
REQ-027 Push while full without a same-cycle pop SHALL drop the event and set overflow; the FIFO contents are unchanged.
REQ-028 Push and pop in the same cycle while full SHALL accept both, leaving occupancy unchanged.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be decided by an extra pointer MSB.

Reset
REQ-030 Reset SHALL force: UART -> IDLE, parser -> HDR, FIFO empty, ev_valid=0, ev_pen=0, ev_x=0, ev_y=0, overflow=0, frame_err=0.
REQ-031 Reset mid-byte or mid-packet SHALL discard the partial data; the next falling edge after reset starts a fresh byte.

Configuration
REQ-032 Macro TOUCH_ERR_CNT_EN defined: SHALL add output err_count [15:0], reset 0.
REQ-033 err_count SHALL increment, saturating at 0xFFFF, on each frame_err, each discarded header, each resync and each dropped push.
REQ-034 Macro TOUCH_ERR_CNT_EN undefined: err_count port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-035 Package touch_pkg SHALL hold the packet constants (HDR_UP=0x80, HDR_DN=0x81), the parser state enum and the touch_event_t struct {pen, x, y}.
REQ-036 UART byte reception SHALL be a sub-module uart_rx_byte (params CLKS_PER_BIT; outputs byte, byte_valid, frame_err); parser and FIFO SHALL live in touch_packet_rx.

Verification
REQ-037 Send bytes 81 12 0F 34 1F -> one event: pen=1, x=0x792, y=0xFB4; ev_valid high 2 cycles after the last stop sample.
REQ-038 Send 80 12 0F 81 01 00 02 00 -> partial packet dropped; one event: pen=1, x=0x001, y=0x002.
REQ-039 Hold ev_ready=0 and send FIFO_DEPTH+1 packets -> exactly FIFO_DEPTH events retained in order and overflow=1; with TOUCH_ERR_CNT_EN, err_count=1.
REQ-040 Hold the stop bit of byte 3 low -> frame_err pulses once, no event; the next clean packet decodes correctly.
REQ-041 Apply a rxd low glitch shorter than CLKS_PER_BIT/2 -> no byte and no error.
REQ-042 Assert reset during byte X1 -> all outputs at reset values; the following full packet yields a correct event.
